pacman_map_writer: RTL and testbench

- Downstream consumer of the pacman location controller's current and next tile coordinates.
- Performs the map-RAM update for one pacman step: reads the target tile, erases pacman from the current tile, and writes pacman into the next tile.
- Returns a one-cycle done pulse, which commits the move in the location controller.
- Also counts pills eaten, detected from the target tile's prior contents, and feeds that count to the score/HUD logic.

---
 rtl/pacman_map_writer.sv | 100 ++++++++++
 tb/tb_pacman_map_writer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_map_writer.sv
// pacman_map_writer: performs one pacman step in map RAM by reading the target tile, erasing the
// current tile and writing pacman into the target, then pulses done and counts the pills eaten.
module pacman_map_writer #(
  parameter int MAP_W = 40,
  parameter int MAP_H = 30,
  parameter logic [3:0] TILE_EMPTY = 4'd0,
  parameter logic [3:0] TILE_WALL = 4'd1,
  parameter logic [3:0] TILE_PILL = 4'd2,
  parameter logic [3:0] TILE_PACMAN = 4'd3
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [5:0]  curr_pacman_x,
  input  logic [4:0]  curr_pacman_y,
  input  logic [5:0]  next_pacman_x,
  input  logic [4:0]  next_pacman_y,
  input  logic [3:0]  ram_rdata,
  output logic [10:0] ram_addr,
  output logic [3:0]  ram_wdata,
  output logic        ram_we,
  output logic        done,
  output logic        busy,
  output logic        pill_eaten,
  output logic [9:0]  pills_eaten,
  output logic        oob_err
);
  localparam logic [5:0] X_LIM = 6'(MAP_W);
  localparam logic [4:0] Y_LIM = 5'(MAP_H);
  if (TILE_PILL == TILE_WALL || TILE_PILL == TILE_EMPTY || TILE_PILL == TILE_PACMAN)
    $error("pill tile code must be distinct from the other tile codes");
  typedef enum logic [2:0] {IDLE, RD_NEXT, RD_WAIT, ERASE, WRITE, FINISH} state_t;
  state_t state;
  logic [5:0] cx, nx;
  logic [4:0] cy, ny;
  logic [3:0] tile_q;
  logic req, in_range;
  assign req = {next_pacman_x, next_pacman_y} != {curr_pacman_x, curr_pacman_y};
  assign in_range = next_pacman_x < X_LIM && next_pacman_y < Y_LIM;
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_we      <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      pill_eaten  <= 1'b0;
      pills_eaten <= '0;
      oob_err     <= 1'b0;
      cx          <= '0;
      cy          <= '0;
      nx          <= '0;
      ny          <= '0;
      tile_q      <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          cx    <= curr_pacman_x;
          cy    <= curr_pacman_y;
          nx    <= next_pacman_x;
          ny    <= next_pacman_y;
          busy  <= 1'b1;
          state <= in_range ? RD_NEXT : FINISH;
          // an out-of-range request skips the RAM entirely and reports at once
          done     <= !in_range;
          oob_err  <= !in_range;
          ram_addr <= in_range ? {next_pacman_y, next_pacman_x} : ram_addr;
        end
        RD_NEXT: state <= RD_WAIT;
        RD_WAIT: begin
          tile_q    <= ram_rdata;
          ram_addr  <= {cy, cx};
          ram_wdata <= TILE_EMPTY;
          ram_we    <= 1'b1;
          state     <= ERASE;
        end
        ERASE: begin
          ram_addr  <= {ny, nx};
          ram_wdata <= TILE_PACMAN;
          state     <= WRITE;
        end
        WRITE: begin
          ram_we      <= 1'b0;
          done        <= 1'b1;
          pill_eaten  <= tile_q == TILE_PILL;
          pills_eaten <= (tile_q == TILE_PILL && pills_eaten != 10'h3ff) ? pills_eaten + 10'd1 : pills_eaten;
          state       <= FINISH;
        end
        FINISH: begin
          done       <= 1'b0;
          pill_eaten <= 1'b0;
          oob_err    <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pacman_map_writer.sv
// tb_pacman_map_writer: randomized scoreboard bench with a map RAM, a location controller and a tile-level model.
module tb_pacman_map_writer;
  localparam logic [3:0] T_EMPTY = 4'd0, T_PILL = 4'd2, T_PACMAN = 4'd3;
  logic CLOCK_50 = 1'b0, reset = 1'b0;
  logic [5:0] curr_pacman_x, next_pacman_x;
  logic [4:0] curr_pacman_y, next_pacman_y;
  logic [3:0] ram_rdata, ram_wdata;
  logic [10:0] ram_addr;
  logic [9:0] pills_eaten;
  logic ram_we, done, busy, pill_eaten, oob_err;
  pacman_map_writer dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .curr_pacman_x(curr_pacman_x), .curr_pacman_y(curr_pacman_y),
    .next_pacman_x(next_pacman_x), .next_pacman_y(next_pacman_y),
    .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .done(done), .busy(busy), .pill_eaten(pill_eaten), .pills_eaten(pills_eaten), .oob_err(oob_err)
  );
  always #10 CLOCK_50 = ~CLOCK_50;

  logic [3:0] mem [2048];
  logic [3:0] model_map [2048];
  always @(posedge CLOCK_50) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end
  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {bit oob; bit pill; int cnt; int at;} txn_t;
  typedef struct {logic [10:0] a; logic [3:0] d;} wr_t;
  txn_t tq[$];
  wr_t wq[$];
  int n_checks = 0, n_err = 0, model_cnt = 0, done_cnt = 0;
  bit sb_on = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [10:0] adr(input logic [5:0] x, input logic [4:0] y);
    return {y, x};
  endfunction

  task automatic set_tile(input logic [5:0] x, input logic [4:0] y, input logic [3:0] t);
    mem[adr(x, y)] <= t;
    model_map[adr(x, y)] = t;
  endtask

  always @(negedge CLOCK_50) if (reset && sb_on && ram_we) begin
    wr_t w;
    if (wq.size() == 0) begin
      n_checks++; n_err++;
      $display("FAIL write_unexpected: addr %0h data %0d expected no write", ram_addr, ram_wdata);
    end else begin
      w = wq.pop_front();
      check("wr_addr", 32'(ram_addr), 32'(w.a));
      check("wr_data", 32'(ram_wdata), 32'(w.d));
    end
  end

  always @(negedge CLOCK_50) if (reset) begin
    txn_t t;
    if (done) begin
      done_cnt++;
      if (tq.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL done_unexpected: done=1 expected 0");
      end else begin
        t = tq.pop_front();
        check("done_cycle", 32'(cyc), 32'(t.at));
        check("oob_err", 32'(oob_err), 32'(t.oob));
        check("pill_eaten", 32'(pill_eaten), 32'(t.pill));
        check("pills_eaten", 32'(pills_eaten), 32'(t.cnt));
        check("busy_at_done", 32'(busy), 32'd1);
      end
    end else if (pill_eaten || oob_err) begin
      n_checks++; n_err++;
      $display("FAIL pulse_without_done: pill_eaten=%0d oob_err=%0d expected 0", pill_eaten, oob_err);
    end
  end

  task automatic move(input logic [5:0] x, input logic [4:0] y);
    txn_t t;
    int k;
    bit oob;
    logic [10:0] na, ca;
    oob = x >= 6'd40 || y >= 5'd30;
    na = adr(x, y);
    ca = adr(curr_pacman_x, curr_pacman_y);
    t.oob = oob;
    t.pill = 1'b0;
    t.at = cyc + (oob ? 1 : 5);
    if (!oob) begin
      t.pill = model_map[na] == T_PILL;
      if (t.pill && model_cnt < 1023) model_cnt++;
      model_map[ca] = T_EMPTY;
      model_map[na] = T_PACMAN;
      wq.push_back('{ca, T_EMPTY});
      wq.push_back('{na, T_PACMAN});
    end
    t.cnt = model_cnt;
    tq.push_back(t);
    next_pacman_x = x;
    next_pacman_y = y;
    @(negedge CLOCK_50);
    if (!oob) begin
      check("rd_addr", 32'(ram_addr), 32'(na));
      check("rd_no_we", 32'(ram_we), 32'd0);
    end
    k = 0;
    while (!done && k < 20) begin
      @(negedge CLOCK_50);
      k++;
    end
    if (!done) begin
      n_checks++; n_err++;
      $display("FAIL done_timeout: done=0 expected 1 within 20 cycles");
    end else if (oob) begin
      next_pacman_x = curr_pacman_x;
      next_pacman_y = curr_pacman_y;
    end else begin
      curr_pacman_x = next_pacman_x;
      curr_pacman_y = next_pacman_y;
    end
    @(negedge CLOCK_50);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, c0, d0, r, d;
    logic [5:0] x;
    logic [4:0] y;
    for (int i = 0; i < 2048; i++) begin
      mem[i] <= T_EMPTY;
      model_map[i] = T_EMPTY;
    end
    curr_pacman_x = 6'd20; curr_pacman_y = 5'd20;
    next_pacman_x = 6'd20; next_pacman_y = 5'd20;
    @(negedge CLOCK_50);
    set_tile(6'd20, 5'd20, T_PACMAN);
    @(negedge CLOCK_50);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pill_eaten", 32'(pill_eaten), 32'd0);
    check("rst_pills_eaten", 32'(pills_eaten), 32'd0);
    check("rst_oob_err", 32'(oob_err), 32'd0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    set_tile(6'd20, 5'd19, T_PILL);
    move(6'd20, 5'd19);
    move(6'd20, 5'd20);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      check("idle_we", 32'(ram_we), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    c0 = model_cnt;
    move(6'd40, 5'd5);
    check("oob_count_kept", 32'(pills_eaten), 32'(c0));
    d0 = done_cnt;
    set_tile(6'd21, 5'd20, T_EMPTY);
    set_tile(6'd22, 5'd20, T_PILL);
    set_tile(6'd23, 5'd20, T_PILL);
    set_tile(6'd24, 5'd20, T_EMPTY);
    for (int i = 1; i <= 4; i++) move(6'(20 + i), 5'd20);
    repeat (5) @(negedge CLOCK_50);
    check("four_done_pulses", 32'(done_cnt - d0), 32'd4);
    check("four_moves_pills", 32'(pills_eaten), 32'(c0 + 2));
    sb_on = 1'b0;
    set_tile(6'd25, 5'd20, T_PILL);
    next_pacman_x = 6'd25;
    k = 0;
    while (!ram_we && k < 10) begin
      @(negedge CLOCK_50);
      k++;
    end
    check("erase_reached", 32'(ram_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_we", 32'(ram_we), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", 32'(pills_eaten), 32'd0);
    model_cnt = 0;
    next_pacman_x = curr_pacman_x;
    @(negedge CLOCK_50);
    reset = 1'b1;
    sb_on = 1'b1;
    @(negedge CLOCK_50);
    check("post_abort_idle", 32'(busy), 32'd0);
    move(6'd25, 5'd20);
    for (int i = 0; i < 200; i++) begin
      x = curr_pacman_x;
      y = curr_pacman_y;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        if ($urandom_range(0, 1) == 1) x = 6'($urandom_range(40, 63));
        else y = 5'($urandom_range(30, 31));
      end else if (r == 1) begin
        while (x == curr_pacman_x && y == curr_pacman_y) begin
          x = 6'($urandom_range(0, 39));
          y = 5'($urandom_range(0, 29));
        end
      end else begin
        d = $urandom_range(0, 3);
        if (d == 0) x = x < 6'd39 ? x + 6'd1 : x - 6'd1;
        else if (d == 1) x = x > 6'd0 ? x - 6'd1 : x + 6'd1;
        else if (d == 2) y = y < 5'd29 ? y + 5'd1 : y - 5'd1;
        else y = y > 5'd0 ? y - 5'd1 : y + 5'd1;
      end
      if (x < 6'd40 && y < 5'd30) set_tile(x, y, 4'($urandom_range(0, 2)));
      move(x, y);
    end
    if (curr_pacman_x != 6'd10 || curr_pacman_y != 5'd10) begin
      set_tile(6'd10, 5'd10, T_EMPTY);
      move(6'd10, 5'd10);
    end
    for (int i = 0; i < 1030; i++) begin
      x = (i % 2 == 0) ? 6'd11 : 6'd10;
      set_tile(x, 5'd10, T_PILL);
      move(x, 5'd10);
    end
    check("saturated_count", 32'(pills_eaten), 32'd1023);
    repeat (3) @(negedge CLOCK_50);
    check("txn_queue_drained", 32'(tq.size()), 32'd0);
    check("write_queue_drained", 32'(wq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
